lfsr_period_display: RTL
========================

// Module: lfsr_period_display
// PURPOSE
//  Downstream consumer of the 4-bit LFSR core. Samples the LFSR word at a
//  prescaled rate for the 7-segment display. Measures the sequence period in
//  clocks and re-measures whenever the mode select changes. Flags an all-zero
//  lockup. Drives uo_out (seg + dp) and exposes the period on a separate port.
// PARAMETERS
//  DIV       8   display sample interval in clocks (>=2)
//  ZERO_LIM  4   consecutive zero words that declare lockup (>=1)
//  CNT_W     8   period counter width; saturates at 2**CNT_W-1
// PORTS
//  clk         in   1      single clock, rising edge
//  reset       in   1      synchronous, active-high
//  lfsr_in     in   4      LFSR word, may change every clock
//  mode_in     in   3      LFSR mode select (same bits that drive the core)
//  hold        in   1      1 = freeze the displayed sample
//  seg_out     out  7      segments {g,f,e,d,c,b,a}, active-high
//  dp_out      out  1      decimal point = period_valid
//  period_out  out  CNT_W  last measured period (0 until valid)
//  lock_out    out  1      sticky all-zero lockup flag
// BEHAVIOUR
//  Reset (sync, active-high, highest priority): pre_cnt=0, disp=0, state=IDLE,
//   ref=0, cnt=0, zcnt=0, period_out=0, dp_out=0, lock_out=0, mode_q<=mode_in.
//   seg_out=7'h3F ("0") during and after reset.
//  Prescaler: pre_cnt counts 0..DIV-1 and wraps. tick = (pre_cnt==DIV-1).
//   On tick with hold=0: disp<=lfsr_in. hold does not stop pre_cnt.
//  seg_out = combinational hex decode of disp, so it changes 1 cycle after the
//   tick edge. In LOCK, seg_out=7'h40 ("-") regardless of disp.
//  mode_q<=mode_in every cycle. mode_chg = (mode_in!=mode_q).
//  zcnt: +1 when lfsr_in==0, saturating at ZERO_LIM; cleared when lfsr_in!=0.
//  FSM priority: reset > mode_chg > lockup > per-state.
//   any state, mode_chg: ->IDLE; dp_out=0, lock_out=0, period_out=0, zcnt=0.
//   any state except LOCK, zcnt==ZERO_LIM-1 and lfsr_in==0: ->LOCK, lock_out=1.
//   IDLE: ->ARM next cycle.
//   ARM:  ref<=lfsr_in; cnt<=1; ->MEAS.
//   MEAS: if lfsr_in==ref: period_out<=cnt, dp_out<=1, ->DONE.
//         else if cnt==max: period_out<=max, dp_out<=1, ->DONE (no repeat).
//         else cnt<=cnt+1.
//   DONE: hold outputs; leave only on mode_chg or reset.
//   LOCK: sticky; leave only on mode_chg (->IDLE) or reset.
//  Period semantics: if ref was captured at edge t0, a match seen on the k-th
//   MEAS cycle gives period k. A free-running maximal 4-bit LFSR gives 15.
//  Reset in any state, including mid-MEAS, discards the partial count. The
//   first measurement starts 2 cycles after reset deasserts.
// STRUCTURE
//  lfsr_mon_pkg: state enum {IDLE,ARM,MEAS,DONE,LOCK}, SEG_DASH=7'h40,
//   SEG_ZERO=7'h3F, 16-entry hex-to-segment constant table.
//  Sub-module hex_to_seg7 (4-bit in, 7-bit out, combinational). Everything
//   else lives in this module.
// TESTING
//  1 Feed maximal sequence 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8 repeating,
//    hold=0 -> period_out=15, dp_out=1 within 18 cycles of reset release.
//  2 Feed counter 1..6 wrapping -> period_out=6; seg_out steps every 8 clks.
//  3 Hold lfsr_in=0 for 4 cycles mid-MEAS -> lock_out=1 on 4th edge,
//    seg_out=7'h40. Change mode_in -> lock_out=0, state IDLE.
//  4 hold=1 while lfsr_in changes for 32 clks -> seg_out unchanged.
//    Release hold -> seg_out updates 1 cycle after the next tick.
//  5 Constant lfsr_in=5 after ARM captured 3 -> period_out=255, dp_out=1.
//  6 Assert reset or change mode_in mid-MEAS (cnt=7) -> period_out=0,
//    dp_out=0. Re-measure of 15-sequence gives 15.

Source files
------------

// File: rtl/lfsr_mon_pkg.sv
// Shared types and constants for the LFSR period/display monitor.
// Holds the FSM state encoding and the 7-segment glyph table.
package lfsr_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEAS,
    DONE,
    LOCK
  } state_t;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_ZERO = 7'h3F;

  // Segments {g,f,e,d,c,b,a}, active-high. Entry 15 is first, entry 0 is last.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, SEG_ZERO
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex digit to 7-segment decoder.
// Output is {g,f,e,d,c,b,a}, active-high.
module hex_to_seg7
  import lfsr_mon_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/lfsr_period_display.sv
// Samples an LFSR word for a 7-segment display, measures its repeat period,
// and flags an all-zero lockup. Re-measures whenever the mode select changes.
module lfsr_period_display
  import lfsr_mon_pkg::*;
#(
  parameter int DIV      = 8,
  parameter int ZERO_LIM = 4,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       lfsr_in,
  input  logic [2:0]       mode_in,
  input  logic             hold,
  output logic [6:0]       seg_out,
  output logic             dp_out,
  output logic [CNT_W-1:0] period_out,
  output logic             lock_out
);

  localparam int PRE_W = $clog2(DIV);
  localparam int ZC_W  = $clog2(ZERO_LIM + 1);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [ZC_W-1:0]  ZC_SAT   = ZC_W'(ZERO_LIM);
  localparam logic [ZC_W-1:0]  ZC_TRIP  = ZC_W'(ZERO_LIM - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [3:0]       disp;
  logic [6:0]       seg_hex;
  logic [2:0]       mode_q;
  logic             mode_chg;
  logic [ZC_W-1:0]  zcnt;

  state_t           state_q, state_d;
  logic [3:0]       ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_d;
  logic             dp_d;
  logic             lock_d;

  assign tick     = (pre_cnt == PRE_LAST);
  assign mode_chg = (mode_in != mode_q);

  // Display sampling: the prescaler keeps running while hold freezes disp.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      disp    <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
      if (tick && !hold) disp <= lfsr_in;
    end
  end

  // The previous mode is captured even during reset, so no spurious
  // re-measure fires on the first cycle after reset releases.
  always_ff @(posedge clk) begin
    mode_q <= mode_in;
  end

  always_ff @(posedge clk) begin
    if (reset || mode_chg)    zcnt <= '0;
    else if (lfsr_in != 4'd0) zcnt <= '0;
    else if (zcnt != ZC_SAT)  zcnt <= zcnt + ZC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ref_q      <= '0;
      cnt_q      <= '0;
      period_out <= '0;
      dp_out     <= 1'b0;
      lock_out   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      cnt_q      <= cnt_d;
      period_out <= period_d;
      dp_out     <= dp_d;
      lock_out   <= lock_d;
    end
  end

  // NOTE: every output of this block is defaulted to its held value first,
  // so paths that do not assign it cannot infer a latch.
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_out;
    dp_d     = dp_out;
    lock_d   = lock_out;

    if (mode_chg) begin
      state_d  = IDLE;
      period_d = '0;
      dp_d     = 1'b0;
      lock_d   = 1'b0;
    end else if (state_q != LOCK && zcnt == ZC_TRIP && lfsr_in == 4'd0) begin
      state_d = LOCK;
      lock_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          ref_d   = lfsr_in;
          cnt_d   = CNT_W'(1);
          state_d = MEAS;
        end
        MEAS: begin
          if (lfsr_in == ref_q) begin
            period_d = cnt_q;
            dp_d     = 1'b1;
            state_d  = DONE;
          end else if (cnt_q == CNT_MAX) begin
            // No repeat within the counter range: report the saturated value.
            period_d = CNT_MAX;
            dp_d     = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  hex_to_seg7 u_hex (
    .hex (disp),
    .seg (seg_hex)
  );

  assign seg_out = (state_q == LOCK) ? SEG_DASH : seg_hex;

endmodule
